// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line settings and
// the oversample-tick divider calculation used by both receive and transmit paths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   localparam int unsigned DEF_CLK_FREQ  = 32'd50_000_000;
   localparam int unsigned DEF_BAUD      = 32'd115_200;
   localparam int unsigned DEF_OVERSAMPLE = 32'd16;

   // Clocks per oversample tick, rounded down.
   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud,
                                            input int unsigned oversample);
      return clk_freq / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks while enabled,
// counter held cleared while disabled.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
   parameter int unsigned BAUD       = DEF_BAUD,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;

   // Divider counter, wraps at DIV-1.
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt_r <= '0;
      end else if (cnt_r == LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   assign tick = en & (cnt_r == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, start-glitch
// rejection and break handling after a framing error.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
   parameter int unsigned BAUD       = DEF_BAUD,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 EN,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] DataOUT,
   output logic                 Valid,
   output logic                 FrameErr,
   output logic                 Busy
);

   localparam int unsigned SW = $clog2(OVERSAMPLE);
   localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] LAST_SMP  = SW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

   logic                 sync1_r;
   logic                 sync2_r;
   logic                 rx_s;
   logic                 tick_s;
   rx_state_t            state_r;
   logic [SW-1:0]        smp_r;
   logic [IW-1:0]        idx_r;
   logic [DATA_BITS-1:0] shreg_r;
   logic [DATA_BITS-1:0] data_r;
   logic                 valid_r;
   logic                 ferr_r;
   logic                 busy_r;

   uart_baud_tick #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk   (CLK),
      .reset (Reset),
      .en    (EN),
      .tick  (tick_s)
   );

   // Two-flop synchroniser for the asynchronous line; resets to idle-high.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= RxD;
         sync2_r <= sync1_r;
      end
   end

   assign rx_s = sync2_r;

   // Frame FSM; counting restarts at the start edge so every sample lands mid-bit.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_r <= IDLE;
         smp_r   <= '0;
         idx_r   <= '0;
         shreg_r <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         if (!EN) begin
            state_r <= IDLE;
            smp_r   <= '0;
            idx_r   <= '0;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (!rx_s) begin
                     state_r <= START;
                     smp_r   <= '0;
                     busy_r  <= 1'b1;
                  end
               end
               START: begin
                  if (tick_s) begin
                     if (smp_r == MID_START) begin
                        smp_r <= '0;
                        if (!rx_s) begin
                           state_r <= DATA;
                           idx_r   <= '0;
                        end else begin
                           state_r <= IDLE;
                           busy_r  <= 1'b0;
                        end
                     end else begin
                        smp_r <= smp_r + SW'(1);
                     end
                  end
               end
               DATA: begin
                  if (tick_s) begin
                     if (smp_r == LAST_SMP) begin
                        smp_r          <= '0;
                        shreg_r[idx_r] <= rx_s;
                        if (idx_r == LAST_BIT) begin
                           state_r <= STOP;
                        end else begin
                           idx_r <= idx_r + IW'(1);
                        end
                     end else begin
                        smp_r <= smp_r + SW'(1);
                     end
                  end
               end
               STOP: begin
                  if (tick_s) begin
                     if (smp_r == LAST_SMP) begin
                        smp_r <= '0;
                        if (rx_s) begin
                           data_r  <= shreg_r;
                           valid_r <= 1'b1;
                           state_r <= IDLE;
                           busy_r  <= 1'b0;
                        end else begin
                           ferr_r  <= 1'b1;
                           state_r <= BREAK;
                        end
                     end else begin
                        smp_r <= smp_r + SW'(1);
                     end
                  end
               end
               BREAK: begin
                  if (rx_s) begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  smp_r   <= '0;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign DataOUT  = data_r;
   assign Valid    = valid_r;
   assign FrameErr = ferr_r;
   assign Busy     = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// scored against a frame-level model of expected pulses, bytes and timing.
module tb_uart_rx;

   localparam int BIT  = 16;
   localparam int SYNC = 2;
   // Valid/FrameErr appear one register after the synchronised mid-stop sample.
   localparam longint LAT = (1 + 8) * BIT + BIT / 2 + SYNC + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] dout;
   logic       valid;
   logic       ferr;
   logic       busy;

   uart_rx #(
      .CLK_FREQ   (1_000_000),
      .BAUD       (62_500),
      .OVERSAMPLE (16),
      .DATA_BITS  (8)
   ) dut (
      .CLK      (clk),
      .Reset    (rst),
      .EN       (en),
      .RxD      (rxd),
      .DataOUT  (dout),
      .Valid    (valid),
      .FrameErr (ferr),
      .Busy     (busy)
   );

   always #5 clk = ~clk;

   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;   // 1 = Valid, 2 = FrameErr
      logic [7:0] data;
      longint     at;
   } ev_t;

   ev_t        expq[$];
   ev_t        obsq[$];
   logic [7:0] last_good = 8'h00;
   bit         mon_on = 1'b0;
   logic       pv = 1'b0;
   logic       pf = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Pulse monitor: records events and checks exclusivity / single-cycle width.
   always @(negedge clk) begin
      if (mon_on) begin
         check("excl", 64'(valid & ferr), 64'd0);
         check("vwidth", 64'(valid & pv), 64'd0);
         check("fwidth", 64'(ferr & pf), 64'd0);
         if (valid) obsq.push_back('{1, dout, cyc});
         if (ferr)  obsq.push_back('{2, dout, cyc});
         pv <= valid;
         pf <= ferr;
      end
   end

   task automatic expect_frame(input logic [7:0] b, input bit ok, input longint start);
      if (ok) begin
         expq.push_back('{1, b, start + LAT});
         last_good = b;
      end else begin
         expq.push_back('{2, last_good, start + LAT});
      end
   endtask

   task automatic send(input logic [7:0] b, input bit ok, input int extra_low);
      logic [9:0] fr;
      fr = {ok, b, 1'b0};
      expect_frame(b, ok, cyc);
      for (int i = 0; i < 10; i++) begin
         rxd = fr[i];
         repeat (BIT) @(negedge clk);
      end
      if (!ok) repeat (extra_low) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic score(input string tag);
      ev_t e;
      ev_t o;
      repeat (3) @(negedge clk);
      check({tag, ".n"}, 64'(obsq.size()), 64'(expq.size()));
      while (expq.size() > 0 && obsq.size() > 0) begin
         e = expq.pop_front();
         o = obsq.pop_front();
         check({tag, ".kind"}, 64'(o.kind), 64'(e.kind));
         check({tag, ".data"}, 64'(o.data), 64'(e.data));
         check({tag, ".at"}, 64'(o.at), 64'(e.at));
      end
      expq.delete();
      obsq.delete();
   endtask

   initial begin
      logic [7:0] fb;
      logic [7:0] rb;
      bit         ok;

      repeat (3) @(negedge clk);
      check("rst.dout", 64'(dout), 64'd0);
      check("rst.valid", 64'(valid), 64'd0);
      check("rst.ferr", 64'(ferr), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      rst = 1'b0;
      en  = 1'b1;
      mon_on = 1'b1;
      idle(5);

      send(8'hEA, 1'b1, 0);
      score("good");
      check("good.dout", 64'(dout), 64'hEA);

      send(8'h55, 1'b1, 0);
      send(8'hA3, 1'b1, 0);
      score("b2b");
      check("b2b.dout", 64'(dout), 64'hA3);

      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      check("glitch.busy1", 64'(busy), 64'd1);
      idle(20);
      check("glitch.busy0", 64'(busy), 64'd0);
      score("glitch");
      send(8'h3C, 1'b1, 0);
      score("after_glitch");
      check("glitch.dout", 64'(dout), 64'h3C);

      send(8'h81, 1'b0, 40);
      check("ferr.busy_brk", 64'(busy), 64'd1);
      idle(5);
      check("ferr.busy0", 64'(busy), 64'd0);
      score("ferr");
      check("ferr.dout", 64'(dout), 64'h3C);

      // Abort 0xFF halfway through data bit 3
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * BIT + BIT / 2) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("abort.busy", 64'(busy), 64'd0);
      @(negedge clk);
      en = 1'b1;
      idle(30);
      score("abort");
      check("abort.dout", 64'(dout), 64'h3C);
      send(8'h12, 1'b1, 0);
      score("after_abort");
      check("abort.dout2", 64'(dout), 64'h12);

      // Reset halfway through data bit 5
      fb = 8'h7E;
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         rxd = fb[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = fb[5];
      repeat (BIT / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mrst.dout", 64'(dout), 64'd0);
      check("mrst.valid", 64'(valid), 64'd0);
      check("mrst.ferr", 64'(ferr), 64'd0);
      check("mrst.busy", 64'(busy), 64'd0);
      rst = 1'b0;
      last_good = 8'h00;
      idle(30);
      score("mrst");
      send(8'h7E, 1'b1, 0);
      score("after_rst");
      check("mrst.dout2", 64'(dout), 64'h7E);

      for (int n = 0; n < 25; n++) begin
         rb = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         send(rb, ok, int'($urandom_range(0, 30)));
         if (ok) idle(int'($urandom_range(0, 20)));
         else    idle(int'($urandom_range(1, 20)));
      end
      score("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: recovers 8N1 UART frames from a single asynchronous input line and presents each received byte as a parallel word with a one-cycle valid pulse.
- Serves as the receive end of the team's UART link. Connects to the transmit line of the existing UART transmit path for loopback, or to an external pin.
- Uses 16x oversampling with mid-bit sampling and start-bit glitch rejection.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, line bit rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4.
- DATA_BITS, 8, payload bits per frame, sent LSB first.

Ports:
- CLK, input, 1, system clock; all logic is on the rising edge.
- Reset, input, 1, synchronous, active-high reset.
- EN, input, 1, receiver enable; when low the receiver is held idle.
- RxD, input, 1, asynchronous serial line; idles high.
- DataOUT, output, DATA_BITS, last correctly received byte; held until the next good frame.
- Valid, output, 1, one-cycle pulse when DataOUT has been updated.
- FrameErr, output, 1, one-cycle pulse when the stop bit is sampled low.
- Busy, output, 1, high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values (Reset sampled high at a CLK edge): DataOUT=0, Valid=0, FrameErr=0, Busy=0, state=IDLE, synchroniser flops=1, all counters=0.
- RxD passes through a 2-flop synchroniser before any use. Synchroniser latency is 2 cycles.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor, and must be >= 1. It emits a one-cycle tick every DIV clocks. It is free-running while EN=1 and held cleared while EN=0.
- Sample counter: 0..OVERSAMPLE-1, advances on each tick and wraps to 0.
- States:
  - IDLE: on synchronised RxD=0 and EN=1, go to START and clear the sample counter.
  - START: on the tick where the counter reaches OVERSAMPLE/2-1 (mid start bit), re-sample RxD. If RxD=0, clear the counter and go to DATA with bit index 0. If RxD=1, treat it as a glitch and return to IDLE with no output pulse.
  - DATA: on each tick where the counter reaches OVERSAMPLE-1 (mid-bit), shift RxD into the shift register at bit[index], LSB first. When index reaches DATA_BITS-1, go to STOP; otherwise increment index.
  - STOP: on the mid-bit sample, if RxD=1, load DataOUT from the shift register, pulse Valid for 1 cycle and go to IDLE. If RxD=0, pulse FrameErr for 1 cycle, leave DataOUT unchanged and go to BREAK.
  - BREAK: wait for synchronised RxD=1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- Latency: Valid rises 1 cycle after the mid-stop-bit sample tick, about 9.5 bit times after the start edge plus 2 synchroniser cycles.
- Valid and FrameErr are never high in the same cycle, and neither is high for more than 1 cycle.
- EN low in any state: return to IDLE on the next edge. Any partial frame is discarded, with no pulse, and DataOUT is unchanged.
- Reset mid-frame: all state returns to reset values on that edge. The partial byte is lost.
- Back-to-back frames: a start edge seen in the cycle after STOP→IDLE is accepted, so no idle gap is required.
- A new Valid pulse overwrites DataOUT. There is no backpressure; an unconsumed byte is simply replaced.

Decomposition:
- Shared package uart_pkg holds:
  - the rx_state_t enum {IDLE, START, DATA, STOP, BREAK};
  - the default CLK_FREQ, BAUD and OVERSAMPLE constants;
  - a function computing DIV. The transmit side reuses these.
- Sub-module uart_baud_tick is the parameterised tick generator with an enable input. The transmit side shares it.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=1_000_000, BAUD=62_500, OVERSAMPLE=16, giving DIV=1 and 16 clocks per bit.
- Good frame: send 0xEA as 8N1 → DataOUT=0xEA, one Valid pulse about 154 cycles after the start edge, FrameErr never asserted.
- Back-to-back frames: send 0x55 then 0xA3 with no idle gap → two Valid pulses 160 cycles apart, with DataOUT=0x55 and then 0xA3.
- Start glitch: drive RxD low for 4 cycles, then high → no Valid, no FrameErr, Busy returns to 0; a following frame 0x3C is received correctly.
- Framing error: send 0x81 with the stop bit low, then hold the line low for 40 cycles → one FrameErr pulse, DataOUT keeps its previous value (0x3C), Busy stays high until RxD returns high, and there is no spurious frame.
- Abort: drop EN at data bit 3 of 0xFF, then raise it again → no pulse, receiver back in IDLE; the next frame 0x12 yields Valid with DataOUT=0x12.
- Reset mid-frame: assert Reset for 1 cycle during data bit 5 → all outputs 0 on the next cycle; the next frame 0x7E is received correctly.
